// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
// Four-requester round-robin front end for a single APB controller.
// One transfer at a time: a winner is picked in IDLE, its command is
// latched, the transfer is driven to the controller, and the result
// (read data / error) is handed back to the owner with a one-cycle ACK.
//
// Handshake: a requester raises REQ[i] with its RW/ADDR/WDATA/STRB and
// keeps it up until it sees ACK[i]. The command is captured on the grant
// edge, so REQ_* may change after GNT[i] rises without affecting the bus.
// A bus transfer completes on the first WAIT edge where
// PENABLE & PREADY_SEL is high. Without completion, the transfer is
// abandoned after TIMEOUT WAIT cycles and returns ERR=1, RD_DATA=0.
// Completion wins if it lands on the final WAIT cycle.
//
// The FSM state is kept in state_q (type state_t) so that checkers can
// bind to it directly.

module apb_master_arbiter #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic         PCLK,
  input  logic         PRESETn,
  input  logic [3:0]   REQ,
  input  logic [3:0]   REQ_RW,
  input  logic [127:0] REQ_ADDR,
  input  logic [127:0] REQ_WDATA,
  input  logic [15:0]  REQ_STRB,
  output logic [3:0]   GNT,
  output logic [3:0]   ACK,
  output logic [31:0]  RD_DATA,
  output logic         ERR,
  output logic         Transfer,
  output logic         RW,
  output logic [31:0]  APB_Address,
  output logic [31:0]  APB_Wr_Data,
  output logic [3:0]   APB_Strobe,
  input  logic [31:0]  APB_Rd_Data,
  input  logic         APB_Error,
  input  logic         PENABLE,
  input  logic         PREADY_SEL
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Counter value seen on the last permitted WAIT cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  // Registered state and outputs
  state_t      state_q;
  logic [1:0]  last_owner_q;
  logic [1:0]  owner_q;
  logic [7:0]  wait_cnt_q;
  logic [3:0]  gnt_q;
  logic [3:0]  ack_q;
  logic [31:0] rd_data_q;
  logic        err_q;
  logic        transfer_q;
  logic        rw_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;

  // Next-state values
  state_t      state_d;
  logic [1:0]  last_owner_d;
  logic [1:0]  owner_d;
  logic [7:0]  wait_cnt_d;
  logic [3:0]  gnt_d;
  logic [3:0]  ack_d;
  logic [31:0] rd_data_d;
  logic        err_d;
  logic        transfer_d;
  logic        rw_d;
  logic [31:0] addr_d;
  logic [31:0] wdata_d;
  logic [3:0]  strb_d;

  // Arbitration result
  logic        win_found;
  logic [1:0]  win_idx;

  // Bus completion as sampled at the clock edge
  logic        xfer_done;
  logic        wait_expired;

  assign xfer_done    = PENABLE & PREADY_SEL;
  assign wait_expired = (wait_cnt_q == TIMEOUT_LAST);

  // Round-robin search starting one past the previous owner, wrapping at 4.
  // The 2-bit sum wraps on its own; i == 4 revisits last_owner itself last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_owner_q;
    for (int i = 1; i <= 4; i++) begin
      if (!win_found && REQ[last_owner_q + 2'(i)]) begin
        win_found = 1'b1;
        win_idx   = last_owner_q + 2'(i);
      end
    end
  end

  // Next-state and output logic; every register holds unless a state acts.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    wait_cnt_d   = wait_cnt_q;
    gnt_d        = gnt_q;
    ack_d        = ack_q;
    rd_data_d    = rd_data_q;
    err_d        = err_q;
    transfer_d   = transfer_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = ISSUE;
          owner_d    = win_idx;
          gnt_d      = 4'b0001 << win_idx;
          rw_d       = REQ_RW[win_idx];
          addr_d     = REQ_ADDR[{win_idx, 5'd0} +: 32];
          wdata_d    = REQ_WDATA[{win_idx, 5'd0} +: 32];
          strb_d     = REQ_STRB[{win_idx, 2'd0} +: 4];
          transfer_d = 1'b1;
        end
      end

      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = 8'd0;
      end

      WAIT: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (xfer_done) begin
          rd_data_d  = rw_q ? 32'd0 : APB_Rd_Data;
          err_d      = APB_Error;
          ack_d      = gnt_q;
          transfer_d = 1'b0;
          state_d    = RESP;
        end else if (wait_expired) begin
          rd_data_d  = 32'd0;
          err_d      = 1'b1;
          ack_d      = gnt_q;
          transfer_d = 1'b0;
          state_d    = RESP;
        end
      end

      RESP: begin
        ack_d        = 4'd0;
        gnt_d        = 4'd0;
        last_owner_d = owner_q;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset; reset favours requester 0.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q      <= IDLE;
      last_owner_q <= 2'd3;
      owner_q      <= 2'd0;
      wait_cnt_q   <= 8'd0;
      gnt_q        <= 4'd0;
      ack_q        <= 4'd0;
      rd_data_q    <= 32'd0;
      err_q        <= 1'b0;
      transfer_q   <= 1'b0;
      rw_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      strb_q       <= 4'd0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      wait_cnt_q   <= wait_cnt_d;
      gnt_q        <= gnt_d;
      ack_q        <= ack_d;
      rd_data_q    <= rd_data_d;
      err_q        <= err_d;
      transfer_q   <= transfer_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
    end
  end

  assign GNT         = gnt_q;
  assign ACK         = ack_q;
  assign RD_DATA     = rd_data_q;
  assign ERR         = err_q;
  assign Transfer    = transfer_q;
  assign RW          = rw_q;
  assign APB_Address = addr_q;
  assign APB_Wr_Data = wdata_q;
  assign APB_Strobe  = strb_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter
// Directed scenarios followed by randomized transfers, each checked
// against a transaction-level model of the arbiter (round-robin winner,
// latched command, completion / timeout result).

module tb_apb_master_arbiter;

  localparam int TO = 32;

  logic         PCLK;
  logic         PRESETn;
  logic [3:0]   REQ;
  logic [3:0]   REQ_RW;
  logic [127:0] REQ_ADDR;
  logic [127:0] REQ_WDATA;
  logic [15:0]  REQ_STRB;
  logic [3:0]   GNT;
  logic [3:0]   ACK;
  logic [31:0]  RD_DATA;
  logic         ERR;
  logic         Transfer;
  logic         RW;
  logic [31:0]  APB_Address;
  logic [31:0]  APB_Wr_Data;
  logic [3:0]   APB_Strobe;
  logic [31:0]  APB_Rd_Data;
  logic         APB_Error;
  logic         PENABLE;
  logic         PREADY_SEL;

  apb_master_arbiter #(.TIMEOUT(TO)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .REQ         (REQ),
    .REQ_RW      (REQ_RW),
    .REQ_ADDR    (REQ_ADDR),
    .REQ_WDATA   (REQ_WDATA),
    .REQ_STRB    (REQ_STRB),
    .GNT         (GNT),
    .ACK         (ACK),
    .RD_DATA     (RD_DATA),
    .ERR         (ERR),
    .Transfer    (Transfer),
    .RW          (RW),
    .APB_Address (APB_Address),
    .APB_Wr_Data (APB_Wr_Data),
    .APB_Strobe  (APB_Strobe),
    .APB_Rd_Data (APB_Rd_Data),
    .APB_Error   (APB_Error),
    .PENABLE     (PENABLE),
    .PREADY_SEL  (PREADY_SEL)
  );

  // ---------------- clock / reset ----------------
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int          checks   = 0;
  int          failures = 0;
  bit          mon_en   = 1'b0;
  int          model_last;       // previous owner in the model
  logic [31:0] exp_rd_hold;      // last result expected on RD_DATA
  logic        exp_err_hold;     // last result expected on ERR
  logic [3:0]  last_gnt;         // GNT observed on the most recent grant
  int          last_xfer_cycles; // cycles Transfer was seen high
  logic [3:0]  exp_q[$];         // expected grant order

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // GNT zero/one-hot and at most one ACK at all times.
  always @(negedge PCLK) begin
    if (mon_en) begin
      checks++;
      assert ($onehot0(GNT) && $onehot0(ACK)) else begin
        failures++;
        $error("FAIL onehot_mon: observed gnt=%b ack=%b expected=zero_or_onehot", GNT, ACK);
      end
    end
  end

  // ---------------- reference model ----------------
  // First requesting index after the previous owner, wrapping modulo 4.
  function automatic int next_winner(input logic [3:0] req, input int last);
    for (int i = 1; i <= 4; i++) begin
      if (req[(last + i) % 4]) return (last + i) % 4;
    end
    return -1;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"},   32'(GNT), 32'd0);
    chk({tag, "_ack"},   32'(ACK), 32'd0);
    chk({tag, "_rd"},    RD_DATA, 32'd0);
    chk({tag, "_err"},   32'(ERR), 32'd0);
    chk({tag, "_xfer"},  32'(Transfer), 32'd0);
    chk({tag, "_rw"},    32'(RW), 32'd0);
    chk({tag, "_addr"},  APB_Address, 32'd0);
    chk({tag, "_wdata"}, APB_Wr_Data, 32'd0);
    chk({tag, "_strb"},  32'(APB_Strobe), 32'd0);
  endtask

  // One full transfer starting from IDLE. REQ_RW/ADDR/WDATA/STRB must be
  // set by the caller. done_k = WAIT cycle (1-based) on which the bus
  // completes; 0 or > TO means the bus never completes (timeout).
  task automatic do_xfer(input logic [3:0] req, input int done_k,
                         input logic [31:0] rdv, input logic errv,
                         input bit keep_req, input bit scramble, input bit chg_addr0);
    int          w;
    logic        e_rw;
    logic [31:0] e_addr, e_wdata, e_rd;
    logic [3:0]  e_strb, e_gnt;
    logic        e_err, completed;
    int          exp_end;
    int          xc;
    bit          pe;

    w       = next_winner(req, model_last);
    e_gnt   = 4'b0001 << w;
    e_rw    = REQ_RW[w];
    e_addr  = REQ_ADDR[32*w +: 32];
    e_wdata = REQ_WDATA[32*w +: 32];
    e_strb  = REQ_STRB[4*w +: 4];
    completed = (done_k >= 1) && (done_k <= TO);
    exp_end   = completed ? done_k : TO;
    e_rd      = (completed && !e_rw) ? rdv : 32'd0;
    e_err     = completed ? errv : 1'b1;

    REQ        = req;
    PENABLE    = 1'b0;
    PREADY_SEL = 1'b0;
    tick();
    // ISSUE
    last_gnt = GNT;
    chk("issue_gnt",   32'(GNT), 32'(e_gnt));
    chk("issue_xfer",  32'(Transfer), 32'd1);
    chk("issue_rw",    32'(RW), 32'(e_rw));
    chk("issue_addr",  APB_Address, e_addr);
    chk("issue_wdata", APB_Wr_Data, e_wdata);
    chk("issue_strb",  32'(APB_Strobe), 32'(e_strb));
    chk("issue_ack",   32'(ACK), 32'd0);
    xc = (Transfer === 1'b1) ? 1 : 0;
    tick();
    // WAIT cycles
    for (int k = 1; k <= exp_end; k++) begin
      if (scramble) begin
        REQ       = 4'($urandom);
        REQ_RW    = 4'($urandom);
        REQ_ADDR  = {$urandom, $urandom, $urandom, $urandom};
        REQ_WDATA = {$urandom, $urandom, $urandom, $urandom};
        REQ_STRB  = 16'($urandom);
      end
      if (chg_addr0 && k == 1) REQ_ADDR[31:0] = 32'h0002_0000;
      if (k == done_k) begin
        PENABLE     = 1'b1;
        PREADY_SEL  = 1'b1;
        APB_Rd_Data = rdv;
        APB_Error   = errv;
      end else begin
        pe          = 1'($urandom_range(0, 1));
        PENABLE     = pe;
        PREADY_SEL  = pe ? 1'b0 : 1'($urandom_range(0, 1));
        APB_Rd_Data = $urandom;
        APB_Error   = 1'($urandom_range(0, 1));
      end
      chk("wait_xfer",  32'(Transfer), 32'd1);
      chk("wait_ack",   32'(ACK), 32'd0);
      chk("wait_gnt",   32'(GNT), 32'(e_gnt));
      chk("wait_addr",  APB_Address, e_addr);
      chk("wait_wdata", APB_Wr_Data, e_wdata);
      if (Transfer === 1'b1) xc++;
      tick();
    end
    // RESP
    PENABLE    = 1'b0;
    PREADY_SEL = 1'b0;
    chk("resp_ack",  32'(ACK), 32'(e_gnt));
    chk("resp_rd",   RD_DATA, e_rd);
    chk("resp_err",  32'(ERR), 32'(e_err));
    chk("resp_xfer", 32'(Transfer), 32'd0);
    chk("resp_addr", APB_Address, e_addr);
    REQ = keep_req ? req : 4'd0;
    tick();
    // IDLE
    chk("idle_ack",  32'(ACK), 32'd0);
    chk("idle_gnt",  32'(GNT), 32'd0);
    chk("idle_xfer", 32'(Transfer), 32'd0);
    chk("idle_rd",   RD_DATA, e_rd);
    chk("idle_err",  32'(ERR), 32'(e_err));
    model_last       = w;
    exp_rd_hold      = e_rd;
    exp_err_hold     = e_err;
    last_xfer_cycles = xc;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int dk;
    int r;

    PRESETn     = 1'b0;
    REQ         = 4'd0;
    REQ_RW      = 4'd0;
    REQ_ADDR    = '0;
    REQ_WDATA   = '0;
    REQ_STRB    = '0;
    APB_Rd_Data = '0;
    APB_Error   = 1'b0;
    PENABLE     = 1'b0;
    PREADY_SEL  = 1'b0;
    model_last  = 3;

    // Reset state
    tick();
    tick();
    check_all_zero("reset");
    mon_en  = 1'b1;
    PRESETn = 1'b1;

    // Fairness: REQ=1111 held, grants 0,1,2,3,0
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    REQ_RW    = 4'b0101;
    REQ_ADDR  = {32'h3000_0030, 32'h2000_0020, 32'h1000_0010, 32'h0000_0000};
    REQ_WDATA = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    REQ_STRB  = 16'h8421;
    for (int n = 0; n < 5; n++) begin
      do_xfer(4'b1111, 1, 32'hCAFE_0000 + 32'(n), 1'b0, (n < 4), 1'b0, 1'b0);
      chk("fair_seq", 32'(last_gnt), 32'(exp_q.pop_front()));
    end

    // Single write from requester 0, completion on 2nd WAIT cycle
    REQ_RW[0]       = 1'b1;
    REQ_ADDR[31:0]  = 32'h0001_0004;
    REQ_WDATA[31:0] = 32'h0000_00A5;
    REQ_STRB[3:0]   = 4'hF;
    do_xfer(4'b0001, 2, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wr_xfer_cycles", 32'(last_xfer_cycles), 32'd3);

    // Read with error from requester 2
    REQ_RW[2]        = 1'b0;
    REQ_ADDR[95:64]  = 32'h0004_0008;
    do_xfer(4'b0100, 3, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0);

    // Timeout: bus never ready, ACK after exactly TO WAIT cycles
    do_xfer(4'b0100, 0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_xfer_cycles", 32'(last_xfer_cycles), 32'(TO + 1));

    // Command isolation: REQ_ADDR[0] changes during WAIT
    REQ_RW[0]      = 1'b1;
    REQ_ADDR[31:0] = 32'h0001_0004;
    do_xfer(4'b0001, 4, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset during WAIT of a requester 1 transfer
    REQ_ADDR[63:32] = 32'h0005_5550;
    REQ = 4'b0010;
    tick();
    chk("rst_issue_gnt", 32'(GNT), 32'h2);
    tick();
    chk("rst_wait_xfer", 32'(Transfer), 32'd1);
    PRESETn = 1'b0;
    REQ     = 4'd0;
    tick();
    check_all_zero("midrst");
    tick();
    chk("midrst_hold_ack", 32'(ACK), 32'd0);
    PRESETn    = 1'b1;
    model_last = 3;
    do_xfer(4'b0011, 1, 32'hAAAA_5555, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_first_gnt", 32'(last_gnt), 32'h1);

    // Idle with no requests: everything holds
    REQ = 4'd0;
    for (int n = 0; n < 3; n++) tick();
    chk("idle_hold_gnt",  32'(GNT), 32'd0);
    chk("idle_hold_xfer", 32'(Transfer), 32'd0);
    chk("idle_hold_rd",   RD_DATA, exp_rd_hold);
    chk("idle_hold_err",  32'(ERR), 32'(exp_err_hold));

    // Randomized transfers, including timeouts and completion-on-last-cycle
    for (int t = 0; t < 24; t++) begin
      REQ_RW    = 4'($urandom);
      REQ_ADDR  = {$urandom, $urandom, $urandom, $urandom};
      REQ_WDATA = {$urandom, $urandom, $urandom, $urandom};
      REQ_STRB  = 16'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0)      dk = 0;
      else if (r == 1) dk = TO;
      else             dk = $urandom_range(1, 6);
      do_xfer(4'($urandom_range(1, 15)), dk, $urandom, 1'($urandom_range(0, 1)),
              1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, 32, maximum WAIT-state cycles before a transfer is aborted (range 2..255).
REQ-002 The block SHALL have the following ports, one per line:
  PCLK  in  1  single clock; all state updates on its rising edge
  PRESETn  in  1  reset, synchronous, active-low
  REQ  in  4  per-requester transfer request; bit i = requester i
  REQ_RW  in  4  per-requester direction: 1 = write, 0 = read
  REQ_ADDR  in  128  requester i address at bits [32i+31:32i]
  REQ_WDATA  in  128  requester i write data at bits [32i+31:32i]
  REQ_STRB  in  16  requester i byte strobes at bits [4i+3:4i]
  GNT  out  4  one-hot current owner; zero when idle
  ACK  out  4  one-cycle completion pulse to the owner
  RD_DATA  out  32  read data returned with ACK
  ERR  out  1  error flag returned with ACK
  Transfer  out  1  enable to the APB controller
  RW  out  1  direction to the APB controller
  APB_Address  out  32  address to the APB controller
  APB_Wr_Data  out  32  write data to the APB controller
  APB_Strobe  out  4  strobes to the APB controller
  APB_Rd_Data  in  32  read data from the APB controller
  APB_Error  in  1  error from the APB controller
  PENABLE  in  1  bus access-phase indicator
  PREADY_SEL  in  1  PREADY of the currently selected slave

Function
REQ-003 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-004 In IDLE with REQ != 0, the block SHALL select a winner round-robin, searching from (last_owner+1) mod 4 upward with wrap-around, and go to ISSUE.
REQ-005 On that same edge, the block SHALL set GNT to the winner and latch its RW, address, write data and strobe into the output registers.
REQ-006 In IDLE with REQ == 0, the FSM SHALL remain in IDLE with all outputs unchanged.
REQ-007 Transfer SHALL be 1 during ISSUE and WAIT and 0 in all other states.
REQ-008 With a request present in cycle N and the FSM in IDLE, Transfer SHALL first be high in cycle N+1.
REQ-009 ISSUE SHALL last exactly one cycle and SHALL go unconditionally to WAIT.
REQ-010 The command outputs (RW, APB_Address, APB_Wr_Data, APB_Strobe) SHALL hold their latched values until the next grant; REQ_* changes after the grant SHALL have no effect.
REQ-011 In WAIT, completion SHALL be PENABLE & PREADY_SEL sampled at the edge.
REQ-012 On completion, the block SHALL register RD_DATA <= APB_Rd_Data when RW=0, else RD_DATA <= 0.
REQ-013 On completion, the block SHALL register ERR <= APB_Error and go to RESP.
REQ-014 A WAIT-cycle counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-015 If the counter reaches TIMEOUT-1 without completion, the block SHALL set ERR=1 and RD_DATA=0 and go to RESP.
REQ-016 If completion and timeout occur in the same cycle, completion SHALL win.
REQ-017 In RESP, ACK[owner] SHALL be 1 for exactly one cycle, and RD_DATA/ERR SHALL be valid in that cycle.
REQ-018 RD_DATA and ERR SHALL hold their values until the next completion or timeout.
REQ-019 In RESP, the block SHALL set last_owner = owner and clear GNT, and the FSM SHALL return to IDLE.
REQ-020 A requester SHALL drop REQ in the cycle after its ACK; a REQ still high in the following IDLE SHALL be treated as a new request.
REQ-021 If the owner's REQ is deasserted mid-transfer, the block SHALL still complete the transfer and still issue its ACK.
REQ-022 Minimum cost SHALL be 4 cycles per transfer (IDLE, ISSUE, one WAIT, RESP), and consecutive grants SHALL be separated by one IDLE cycle.
REQ-023 At most one ACK bit SHALL be high in any cycle, and GNT SHALL be zero or one-hot at all times.

Reset
REQ-024 With PRESETn=0 at an edge, the block SHALL go to IDLE and set last_owner=3, so requester 0 has first priority.
REQ-025 With PRESETn=0 at an edge, the block SHALL clear the counter and set every output to 0: GNT, ACK, RD_DATA, ERR, Transfer, RW, APB_Address, APB_Wr_Data, APB_Strobe.
REQ-026 A reset during ISSUE, WAIT or RESP SHALL abort the transfer, and the aborted transfer SHALL never receive an ACK.

Verification
REQ-027 The bench SHALL cover a single write: REQ[0]=1, RW=1, addr 0x0001_0004, data 0x0000_00A5, strobe 0xF, PREADY_SEL&PENABLE high on the 2nd WAIT cycle -> Transfer high 3 cycles, then ACK=0001 for one cycle, ERR=0, RD_DATA=0.
REQ-028 The bench SHALL cover a read with error: REQ[2], RW=0, APB_Rd_Data=0xDEADBEEF, APB_Error=1 at completion -> ACK=0100, RD_DATA=0xDEADBEEF, ERR=1.
REQ-029 The bench SHALL cover fairness: REQ=1111 held continuously -> GNT sequence 0001, 0010, 0100, 1000, 0001; no requester is granted twice before the others.
REQ-030 The bench SHALL cover timeout: PREADY_SEL held 0, TIMEOUT=32 -> ACK after exactly 32 WAIT cycles with ERR=1, RD_DATA=0.
REQ-031 The bench SHALL cover reset mid-transfer: PRESETn=0 during WAIT of a requester 1 transfer -> next cycle all outputs 0, no ACK; after release with REQ=0011, GNT=0001 first.
REQ-032 The bench SHALL cover command isolation: REQ_ADDR[0] changed to 0x0002_0000 during WAIT -> APB_Address keeps 0x0001_0004 until ACK.
